// File: rtl/fft_stage_ctrl.sv
// Stage sequencer for the in-place ping-pong FFT: read/twiddle address streams, delayed write strobes, RAM-set swap per stage.
// Optional cycle counter output oCYCLES is built when FFT_CTRL_CYCLE_CNT_EN is defined.
module fft_stage_ctrl #(
    parameter int ADDR_W   = 9,
    parameter int STAGES   = 6,
    parameter int PIPE_LAT = 4
) (
    input  logic              iCLK,
    input  logic              iRESET,
    input  logic              iSTART,
    output logic [ADDR_W-1:0] oADDR_RD,
    output logic [ADDR_W-1:0] oADDR_WR,
    output logic              oWE,
    output logic [ADDR_W-1:0] oTW_ADDR,
    output logic              oRAM_SEL,
    output logic [3:0]        oSTAGE,
    output logic              oBUSY,
`ifdef FFT_CTRL_CYCLE_CNT_EN
    output logic [15:0]       oCYCLES,
`endif
    output logic              oRDY
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [3:0] LAST_STAGE = 4'(STAGES - 1);
    localparam logic [3:0] DRAIN_LAST = 4'(PIPE_LAT - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   k_q, k_d;
    logic [3:0]          stage_q, stage_d;
    logic [3:0]          drain_q, drain_d;
    logic                ram_sel_q, ram_sel_d;
    logic                rdy_q, rdy_d;
    logic [PIPE_LAT-1:0] vld_q;
    logic [ADDR_W-1:0]   tag_q [PIPE_LAT];
    logic                start_ok;
    logic                busy;

    assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign start_ok = iSTART && ((state_q == S_IDLE) || (state_q == S_DONE));

    // NOTE: every variable gets its hold value first so no path through the case leaves one unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        stage_d   = stage_q;
        drain_d   = drain_q;
        ram_sel_d = ram_sel_q;
        rdy_d     = rdy_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (iSTART) begin
                    state_d   = S_RUN;
                    k_d       = '0;
                    stage_d   = '0;
                    ram_sel_d = 1'b0;
                    rdy_d     = 1'b0;
                end
            end
            S_RUN: begin
                k_d     = k_q + 1'b1;
                drain_d = '0;
                if (k_q == '1) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                drain_d = drain_q + 4'd1;
                if (drain_q == DRAIN_LAST) begin
                    drain_d   = '0;
                    ram_sel_d = ~ram_sel_q;
                    if (stage_q == LAST_STAGE) begin
                        state_d = S_DONE;
                        rdy_d   = 1'b1;
                    end else begin
                        stage_d = stage_q + 4'd1;
                        state_d = S_RUN;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            stage_q   <= '0;
            drain_q   <= '0;
            ram_sel_q <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            stage_q   <= stage_d;
            drain_q   <= drain_d;
            ram_sel_q <= ram_sel_d;
            rdy_q     <= rdy_d;
        end
    end

    // A tag only moves with its valid bit, so the last stage keeps the most recent write address between writes.
    // NOTE: the tag line is a small register array, not RAM, so it is reset to give oADDR_WR a defined 0 out of reset.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            vld_q <= '0;
            for (int i = 0; i < PIPE_LAT; i++) tag_q[i] <= '0;
        end else begin
            vld_q[0] <= (state_q == S_RUN);
            if (state_q == S_RUN) tag_q[0] <= k_q;
            for (int i = 1; i < PIPE_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) tag_q[i] <= tag_q[i-1];
            end
        end
    end

`ifdef FFT_CTRL_CYCLE_CNT_EN
    logic [15:0] cycles_q, cycles_d;

    always_comb begin
        cycles_d = cycles_q;
        if (start_ok)                        cycles_d = '0;
        else if (busy && (cycles_q != '1))   cycles_d = cycles_q + 16'd1;
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) cycles_q <= '0;
        else        cycles_q <= cycles_d;
    end

    assign oCYCLES = cycles_q;
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
`endif

    assign oADDR_RD = k_q;
    assign oTW_ADDR = k_q << {stage_q, 1'b0};
    assign oADDR_WR = tag_q[PIPE_LAT-1];
    assign oWE      = vld_q[PIPE_LAT-1];
    assign oRAM_SEL = ram_sel_q;
    assign oSTAGE   = stage_q;
    assign oBUSY    = busy;
    assign oRDY     = rdy_q;

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Bench for fft_stage_ctrl: default build (6 stages, latency 4) and a 1-stage latency-1 build share one random stimulus.
module tb_fft_stage_ctrl;

    localparam int AW = 9;
    localparam int N  = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;

    always #5 clk = ~clk;

    logic [1:0][AW-1:0] rd, wr, tw;
    logic [1:0][3:0]    stg;
    logic [1:0]         we, sel, busy, rdy;
`ifdef FFT_CTRL_CYCLE_CNT_EN
    logic [1:0][15:0]   cyc;
`endif

    fft_stage_ctrl #(.ADDR_W(AW), .STAGES(6), .PIPE_LAT(4)) u_big (
        .iCLK(clk), .iRESET(rst), .iSTART(start),
        .oADDR_RD(rd[0]), .oADDR_WR(wr[0]), .oWE(we[0]), .oTW_ADDR(tw[0]),
        .oRAM_SEL(sel[0]), .oSTAGE(stg[0]), .oBUSY(busy[0]),
`ifdef FFT_CTRL_CYCLE_CNT_EN
        .oCYCLES(cyc[0]),
`endif
        .oRDY(rdy[0])
    );

    fft_stage_ctrl #(.ADDR_W(AW), .STAGES(1), .PIPE_LAT(1)) u_small (
        .iCLK(clk), .iRESET(rst), .iSTART(start),
        .oADDR_RD(rd[1]), .oADDR_WR(wr[1]), .oWE(we[1]), .oTW_ADDR(tw[1]),
        .oRAM_SEL(sel[1]), .oSTAGE(stg[1]), .oBUSY(busy[1]),
`ifdef FFT_CTRL_CYCLE_CNT_EN
        .oCYCLES(cyc[1]),
`endif
        .oRDY(rdy[1])
    );

    int total = 0;
    int bad   = 0;

    // Reference model: elapsed cycles since the first RUN cycle determine everything.
    bit run_m  [2];
    bit done_m [2];
    int t_m    [2];
    int lastwr_m [2];
    int cyc_m  [2];

    function automatic int lat_of(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic int stages_of(input int d);
        return (d == 0) ? 6 : 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 25) $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            run_m[d] = 0; done_m[d] = 0; t_m[d] = 0; lastwr_m[d] = 0; cyc_m[d] = 0;
        end
    endtask

    task automatic model_edge(input bit st);
        for (int d = 0; d < 2; d++) begin
            int run_len;
            run_len = stages_of(d) * (N + lat_of(d));
            if (run_m[d]) begin
                t_m[d]++;
                if (t_m[d] == run_len) begin
                    run_m[d] = 0; done_m[d] = 1; cyc_m[d] = run_len;
                end
            end else if (st) begin
                run_m[d] = 1; done_m[d] = 0; t_m[d] = 0;
            end
        end
    endtask

    task automatic compare();
        for (int d = 0; d < 2; d++) begin
            int p, s, w, e_rd, e_tw, e_we, e_sel, e_cyc;
            p = N + lat_of(d);
            s = 0; e_rd = 0; e_tw = 0; e_we = 0; e_sel = 0;
            if (run_m[d]) begin
                s     = t_m[d] / p;
                w     = t_m[d] % p;
                e_rd  = (w < N) ? w : 0;
                e_tw  = (e_rd << (2 * s)) % N;
                e_we  = (w >= lat_of(d) && w < N + lat_of(d)) ? 1 : 0;
                e_sel = s % 2;
                if (e_we != 0) lastwr_m[d] = w - lat_of(d);
                e_cyc = t_m[d];
            end else begin
                e_sel = done_m[d] ? (stages_of(d) % 2) : 0;
                e_cyc = cyc_m[d];
            end
            check($sformatf("rd%0d", d),   rd[d],   e_rd);
            check($sformatf("tw%0d", d),   tw[d],   e_tw);
            check($sformatf("we%0d", d),   we[d],   e_we);
            check($sformatf("wr%0d", d),   wr[d],   lastwr_m[d]);
            check($sformatf("sel%0d", d),  sel[d],  e_sel);
            check($sformatf("busy%0d", d), busy[d], run_m[d]);
            check($sformatf("rdy%0d", d),  rdy[d],  done_m[d]);
            if (run_m[d] || !done_m[d]) check($sformatf("stage%0d", d), stg[d], s);
`ifdef FFT_CTRL_CYCLE_CNT_EN
            check($sformatf("cyc%0d", d), cyc[d], e_cyc);
`endif
        end
    endtask

    task automatic tick(input bit st);
        @(negedge clk);
        start = st;
        @(posedge clk);
        model_edge(st);
        #1;
        compare();
    endtask

    // Starts a run and lets both builds finish; with noise, stray iSTART pulses hit the busy default build.
    task automatic run_to_idle(input bit noise);
        int guard;
        guard = 0;
        tick(1'b1);
        while ((run_m[0] || run_m[1]) && guard < 5000) begin
            tick(noise && run_m[0] && (t_m[0] == 2 * 516 + 100 || $urandom_range(0, 19) == 0));
            guard++;
        end
        check("run_timeout", guard >= 5000, 0);
    endtask

    initial begin
        int target, guard;
        model_reset();
        repeat (3) @(posedge clk);
        #1 compare();
        @(negedge clk) rst = 1'b0;
        repeat ($urandom_range(1, 5)) tick(1'b0);

        run_to_idle(1'b1);
        repeat ($urandom_range(2, 6)) tick(1'b0);

        // Second run is aborted by reset somewhere inside the stage-3 drain window.
        tick(1'b1);
        target = 3 * 516 + 512 + $urandom_range(0, 3);
        guard = 0;
        while (run_m[0] && t_m[0] < target && guard < 5000) begin
            tick(1'b0);
            guard++;
        end
        check("abort_reached", t_m[0], target);
        #2 rst = 1'b1;
        model_reset();
        #1 compare();
        repeat (2) begin
            @(posedge clk);
            #1 compare();
        end
        @(negedge clk) rst = 1'b0;
        repeat ($urandom_range(5, 12)) tick(1'b0);

        run_to_idle(1'b0);
        repeat (3) tick(1'b0);
        run_to_idle(1'b1);
        tick(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_stage_ctrl.md
Name: fft_stage_ctrl

Overview:
- Sequences the in-place FFT over the 4-bank 512-word ping-pong RAM sets (A/B) inside fft_top.
- Per stage: streams one butterfly per clock (common read address to all 4 banks, twiddle address, delayed write address/enable), then drains the butterfly pipeline, swaps RAM sets, advances stage.
- Raises oRDY as a level when all stages are done; the host polls it before reading results.

Parameters:
- ADDR_W, 9, bank address width; butterfly count per stage = 2**ADDR_W.
- STAGES, 6, number of passes; 1..15.
- PIPE_LAT, 4, butterfly datapath latency in cycles, read-address issue to write; 1..15.

Ports:
- iCLK  in  1  clock.
- iRESET  in  1  asynchronous reset, active-high.
- iSTART  in  1  one-cycle start request.
- oADDR_RD  out  ADDR_W  read address, common to banks 0..3.
- oADDR_WR  out  ADDR_W  write address, common to banks 0..3.
- oWE  out  1  write enable for all 4 banks of the write-side set.
- oTW_ADDR  out  ADDR_W  twiddle ROM address, aligned with oADDR_RD.
- oRAM_SEL  out  1  0 = read A / write B; 1 = read B / write A.
- oSTAGE  out  4  current stage index.
- oBUSY  out  1  high in RUN or DRAIN.
- oRDY  out  1  results valid; level.

Behaviour:
- Reset (async, immediate): state=IDLE. All outputs 0: addresses, oWE, oRAM_SEL, oSTAGE, oBUSY, oRDY. The write-valid shift register is cleared.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE, DONE:
  - iSTART=1 -> RUN at the next edge.
  - On that edge: k=0, stage=0, oRAM_SEL=0, oRDY=0.
- RUN:
  - Each cycle: oADDR_RD=k, oTW_ADDR=(k<<(2*stage)) mod 2**ADDR_W; a valid bit with tag k enters the delay line.
  - k increments each cycle.
  - At k=2**ADDR_W-1 -> DRAIN (k wraps to 0).
- Write side: valid/tag delayed exactly PIPE_LAT cycles. oWE=1 and oADDR_WR=tag in the cycle PIPE_LAT after the matching read. oADDR_WR holds its last value when oWE=0.
- DRAIN:
  - Lasts exactly PIPE_LAT cycles; oADDR_RD holds 0; the final write of the stage lands in the last DRAIN cycle.
  - If stage<STAGES-1: stage+1, oRAM_SEL toggles, -> RUN.
  - Else: oRAM_SEL toggles, -> DONE with oRDY=1.
- Timing:
  - Stage period = 2**ADDR_W + PIPE_LAT cycles.
  - oRDY rises STAGES*(2**ADDR_W+PIPE_LAT) cycles after the first RUN cycle: 3096 with defaults.
  - Final oRAM_SEL = STAGES mod 2; the result set is the read side indicated.
- oBUSY=1 exactly in RUN/DRAIN. iSTART is ignored while oBUSY=1.
- oRDY stays high in DONE until the next accepted iSTART.
- No write overlaps a read of the same set: a RAM swap happens only after DRAIN completes.
- Reset mid-RUN/DRAIN aborts immediately: oWE drops asynchronously and no stale writes occur after release.

Optional Feature:
- Macro FFT_CTRL_CYCLE_CNT_EN.
- Defined: adds output oCYCLES[15:0].
  - Cleared on accepted iSTART; increments every RUN/DRAIN cycle; saturates at 16'hFFFF.
  - Frozen in DONE; 0 on reset.
  - Default run reads 3096.
- Undefined: port and counter absent; no other behaviour change.

Test Plan:
- Reset held, then released; iSTART pulse -> next cycle oBUSY=1, oADDR_RD=0, oRAM_SEL=0, oSTAGE=0; oWE first high 4 cycles later with oADDR_WR=0.
- Full run with defaults -> oRDY rises 3096 cycles after the first RUN cycle; oSTAGE sequence 0..5; oRAM_SEL toggles at cycles 516, 1032, ...; final 0; exactly 6*512 oWE cycles; write addresses 0..511 in order per stage.
- Stage 1, k=3 -> oTW_ADDR=12; stage 4, k=1 -> oTW_ADDR=256 (1<<8); stage 5, k=1 -> 0 (1<<10 mod 512).
- iSTART pulsed mid-stage 2 -> ignored; completion time and address streams unchanged.
- iRESET asserted during stage 3 DRAIN -> oWE, oBUSY, oRDY 0 in the same cycle; after release, no oWE until a new iSTART; a new run completes normally.
- PIPE_LAT=1, STAGES=1 -> oRDY 513 cycles after RUN start; oRAM_SEL=1 in DONE; with FFT_CTRL_CYCLE_CNT_EN, oCYCLES=513.
